mc_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the miniRV datapath. It steps each instruction through a shared ALU and a single-port unified instruction/data memory. It classifies the IR opcode and drives the per-state write enables, the memory handshake and the PC/writeback selects. The pc_sel and reg_write encodings match the decoder's: pc_sel 00 pc+4, 01 jal, 10 jalr, 11 branch; reg_write 00 ALU, 01 pc+4, 10 mem, 11 imm. It sits between the IR/PC/register-file datapath and the memory port.

---
 rtl/mc_seq_ctrl_if.sv | 11 +
 rtl/mc_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mc_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_seq_ctrl_if.sv
// Memory-port handshake between the miniRV sequencer and the unified I/D memory.
// The sequencer owns request, store strobe and address select; the memory returns ready.
interface mc_seq_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle sequencer for the miniRV datapath: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP.
// Control outputs are a pure function of state, latched class and the current-cycle inputs.
module mc_seq_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [6:0]           ir_opcode,
    input  logic                 branch_taken,
    mc_seq_ctrl_if.master        mem,
    output logic                 ir_we,
    output logic                 opnd_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 reg_we,
    output logic [1:0]           reg_write,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [2:0] C_R     = 3'd0;
    localparam logic [2:0] C_I     = 3'd1;
    localparam logic [2:0] C_LOAD  = 3'd2;
    localparam logic [2:0] C_STORE = 3'd3;
    localparam logic [2:0] C_BR    = 3'd4;
    localparam logic [2:0] C_JAL   = 3'd5;
    localparam logic [2:0] C_JALR  = 3'd6;
    localparam logic [2:0] C_LUI   = 3'd7;

    logic [2:0]           state_q, state_d;
    logic [2:0]           cls_q, cls_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    logic [2:0] dec_cls;
    logic       dec_valid;
    logic       retire;
    logic       mem_req_c, mem_we_c, mem_addr_sel_c;
    logic       ir_we_c, opnd_we_c, pc_we_c, reg_we_c, illegal_c;
    logic [1:0] pc_sel_c, reg_write_c;

    always_comb begin
        dec_valid = 1'b1;
        dec_cls   = C_R;
        case (ir_opcode)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BR;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b0110111: dec_cls = C_LUI;
            default:    dec_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cls_d          = cls_q;
        retire         = 1'b0;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_sel_c = 1'b0;
        ir_we_c        = 1'b0;
        opnd_we_c      = 1'b0;
        pc_we_c        = 1'b0;
        pc_sel_c       = 2'b00;
        reg_we_c       = 1'b0;
        reg_write_c    = 2'b00;
        illegal_c      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c = run;
                ir_we_c   = run & mem.mem_ready;
                if (run && mem.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                opnd_we_c = 1'b1;
                // Class is only captured for legal opcodes; TRAP never reads it.
                if (dec_valid) begin
                    cls_d   = dec_cls;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_EXEC: begin
                if (cls_q == C_BR) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = branch_taken ? 2'b11 : 2'b00;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                mem_we_c       = (cls_q == C_STORE);
                if (mem.mem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_we_c = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                pc_we_c  = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
                case (cls_q)
                    C_JAL, C_JALR: reg_write_c = 2'b01;
                    C_LOAD:        reg_write_c = 2'b10;
                    C_LUI:         reg_write_c = 2'b11;
                    default:       reg_write_c = 2'b00;
                endcase
                case (cls_q)
                    C_JAL:   pc_sel_c = 2'b01;
                    C_JALR:  pc_sel_c = 2'b10;
                    default: pc_sel_c = 2'b00;
                endcase
            end
            S_TRAP: illegal_c = 1'b1;
            default: state_d = S_FETCH;
        endcase
        instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= C_R;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            instret_q <= instret_d;
        end
    end

    // While reset is held every strobe is forced low, so an in-flight request drops at once.
    assign mem.mem_req      = mem_req_c & rst_n;
    assign mem.mem_we       = mem_we_c & rst_n;
    assign mem.mem_addr_sel = mem_addr_sel_c & rst_n;
    assign ir_we            = ir_we_c & rst_n;
    assign opnd_we          = opnd_we_c & rst_n;
    assign pc_we            = pc_we_c & rst_n;
    assign pc_sel           = pc_sel_c & {2{rst_n}};
    assign reg_we           = reg_we_c & rst_n;
    assign reg_write        = reg_write_c & {2{rst_n}};
    assign illegal          = illegal_c & rst_n;
    assign instret          = instret_q;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Randomised bench for mc_seq_ctrl: per-instruction latency/strobe model plus a 4-bit instret wrap instance.
module tb_mc_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [6:0]  ir_opcode;
    logic        branch_taken;
    logic        ir_we, opnd_we, pc_we, reg_we, illegal;
    logic [1:0]  pc_sel, reg_write;
    logic [31:0] instret;

    logic        run2;
    logic [6:0]  opc2;
    logic        taken2;
    logic        ir_we2, opnd_we2, pc_we2, reg_we2, illegal2;
    logic [1:0]  pc_sel2, reg_write2;
    logic [3:0]  instret2;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] instret_m = '0;

    mc_seq_ctrl_if mif ();
    mc_seq_ctrl_if mif2 ();

    mc_seq_ctrl #(.INSTRET_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ir_opcode(ir_opcode), .branch_taken(branch_taken),
        .mem(mif), .ir_we(ir_we), .opnd_we(opnd_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .reg_we(reg_we), .reg_write(reg_write), .illegal(illegal), .instret(instret)
    );

    mc_seq_ctrl #(.INSTRET_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .run(run2), .ir_opcode(opc2), .branch_taken(taken2),
        .mem(mif2), .ir_we(ir_we2), .opnd_we(opnd_we2), .pc_we(pc_we2), .pc_sel(pc_sel2),
        .reg_we(reg_we2), .reg_write(reg_write2), .illegal(illegal2), .instret(instret2)
    );

    always #5 clk = ~clk;

    // Architectural expectations per opcode: zero-wait latency and the retirement-cycle selects.
    function automatic void exp_of(input logic [6:0] op, input logic taken, output int base,
                                   output logic rw_en, output logic [1:0] rw, output logic [1:0] ps,
                                   output logic is_mem, output logic is_st);
        base = 4; rw_en = 1'b1; rw = 2'b00; ps = 2'b00; is_mem = 1'b0; is_st = 1'b0;
        case (op)
            7'b0110011, 7'b0010011: ;
            7'b0110111: rw = 2'b11;
            7'b1101111: begin rw = 2'b01; ps = 2'b01; end
            7'b1100111: begin rw = 2'b01; ps = 2'b10; end
            7'b0000011: begin base = 5; rw = 2'b10; is_mem = 1'b1; end
            7'b0100011: begin rw_en = 1'b0; is_mem = 1'b1; is_st = 1'b1; end
            7'b1100011: begin base = 3; rw_en = 1'b0; ps = taken ? 2'b11 : 2'b00; end
            default: base = 0;
        endcase
    endfunction

    task automatic drive_instr(input logic [6:0] op, input logic taken, input int fw, input int mw,
                               input string tag);
        int base, fw_left, mw_left, lat, exp_lat;
        int n_ir, n_opnd, n_reg, n_we, n_mph;
        logic rw_en, is_mem, is_st, bad_inv, reg_obs;
        logic [1:0] rw_exp, ps_exp, ps_obs, rw_obs;
        exp_of(op, taken, base, rw_en, rw_exp, ps_exp, is_mem, is_st);
        exp_lat = base + fw + (is_mem ? mw : 0);
        ir_opcode = op; branch_taken = taken; run = 1'b1;
        fw_left = fw; mw_left = mw; lat = 0;
        n_ir = 0; n_opnd = 0; n_reg = 0; n_we = 0; n_mph = 0;
        bad_inv = 1'b0; reg_obs = 1'b0; ps_obs = 2'b00; rw_obs = 2'b00;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (mif.mem_req && !mif.mem_addr_sel) begin
                mif.mem_ready = (fw_left == 0);
                if (fw_left > 0) fw_left--;
            end else if (mif.mem_req) begin
                mif.mem_ready = (mw_left == 0);
                if (mw_left > 0) mw_left--;
            end else begin
                mif.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            n_ir   += int'(ir_we);
            n_opnd += int'(opnd_we);
            n_reg  += int'(reg_we);
            n_we   += int'(mif.mem_we);
            n_mph  += int'(mif.mem_req && mif.mem_addr_sel);
            if ((mif.mem_we && !mif.mem_req) || illegal) bad_inv = 1'b1;
            if (pc_we) begin
                lat = c; ps_obs = pc_sel; rw_obs = reg_write; reg_obs = reg_we;
                break;
            end
        end
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", tag, lat, exp_lat); end
        checks++;
        if (ps_obs !== ps_exp) begin errors++; $display("FAIL %s pc_sel got %b want %b", tag, ps_obs, ps_exp); end
        checks++;
        if (reg_obs !== rw_en) begin errors++; $display("FAIL %s reg_we@retire got %b want %b", tag, reg_obs, rw_en); end
        if (rw_en) begin
            checks++;
            if (rw_obs !== rw_exp) begin errors++; $display("FAIL %s reg_write got %b want %b", tag, rw_obs, rw_exp); end
        end
        checks++;
        if (n_ir !== 1 || n_opnd !== 1) begin
            errors++; $display("FAIL %s ir_we/opnd_we pulses got %0d/%0d want 1/1", tag, n_ir, n_opnd);
        end
        checks++;
        if (n_reg !== (rw_en ? 1 : 0)) begin errors++; $display("FAIL %s reg_we pulses got %0d want %0d", tag, n_reg, rw_en ? 1 : 0); end
        checks++;
        if (n_mph !== (is_mem ? mw + 1 : 0) || n_we !== (is_st ? mw + 1 : 0)) begin
            errors++;
            $display("FAIL %s data-access cycles got req=%0d we=%0d want req=%0d we=%0d", tag, n_mph, n_we,
                     is_mem ? mw + 1 : 0, is_st ? mw + 1 : 0);
        end
        checks++;
        if (bad_inv !== 1'b0) begin errors++; $display("FAIL %s mem_we-without-req or illegal seen got 1 want 0", tag); end
        @(posedge clk); #1;
        instret_m++;
        checks++;
        if (instret !== instret_m) begin errors++; $display("FAIL %s instret got %0d want %0d", tag, instret, instret_m); end
    endtask

    task automatic release_reset();
        mif.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; ir_opcode = 7'b0110011; branch_taken = 1'b0;
        mif.mem_ready = 1'b1; mif2.mem_ready = 1'b1;
        run2 = 1'b0; opc2 = 7'b0110011; taken2 = 1'b0;
        #3;
        checks++;
        if (mif.mem_req !== 1'b0 || ir_we !== 1'b0 || pc_we !== 1'b0 || illegal !== 1'b0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL reset outputs got req=%b ir_we=%b pc_we=%b ill=%b instret=%0d want all 0",
                     mif.mem_req, ir_we, pc_we, illegal, instret);
        end
        release_reset();
        instret_m = '0;
        checks++;
        if (mif.mem_req !== 1'b1) begin errors++; $display("FAIL fetch_after_reset mem_req got %b want 1", mif.mem_req); end
    endtask

    task automatic test_r_type();
        drive_instr(7'b0110011, 1'b0, 0, 0, "r_type");
        drive_instr(7'b0010011, 1'b0, 0, 0, "i_type");
    endtask

    task automatic test_load_wait();
        drive_instr(7'b0000011, 1'b0, 0, 2, "load_wait2");
        drive_instr(7'b0100011, 1'b0, 0, 0, "store_nowait");
    endtask

    task automatic test_branch();
        drive_instr(7'b1100011, 1'b1, 0, 0, "branch_taken");
        drive_instr(7'b1100011, 1'b0, 0, 0, "branch_not_taken");
    endtask

    task automatic test_jumps();
        drive_instr(7'b1101111, 1'b0, 0, 0, "jal");
        drive_instr(7'b1100111, 1'b0, 0, 0, "jalr");
        drive_instr(7'b0110111, 1'b0, 0, 0, "lui");
    endtask

    task automatic test_random();
        logic [6:0] ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        int gap;
        for (int i = 0; i < 40; i++) begin
            drive_instr(ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                        $urandom_range(0, 2), $urandom_range(0, 3), "random");
            if ($urandom_range(0, 3) == 0) begin
                run = 1'b0; mif.mem_ready = 1'b0;
                gap = $urandom_range(1, 4);
                for (int k = 0; k < gap; k++) begin
                    @(negedge clk);
                    mif.mem_ready = 1'($urandom_range(0, 1));
                    #1;
                    checks++;
                    if (mif.mem_req !== 1'b0 || ir_we !== 1'b0 || instret !== instret_m) begin
                        errors++;
                        $display("FAIL idle req=%b ir_we=%b instret=%0d want 0 0 %0d", mif.mem_req, ir_we, instret, instret_m);
                    end
                end
                mif.mem_ready = 1'b0;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_trap();
        logic bad;
        ir_opcode = 7'b1110011; run = 1'b1;
        @(negedge clk); mif.mem_ready = 1'b1; #1;
        checks++;
        if (ir_we !== 1'b1) begin errors++; $display("FAIL trap_fetch ir_we got %b want 1", ir_we); end
        @(negedge clk); #1;
        checks++;
        if (opnd_we !== 1'b1 || illegal !== 1'b0) begin
            errors++; $display("FAIL trap_decode opnd_we=%b illegal=%b want 1 0", opnd_we, illegal);
        end
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); mif.mem_ready = 1'($urandom_range(0, 1)); #1;
            if (illegal !== 1'b1 || mif.mem_req !== 1'b0 || ir_we || opnd_we || pc_we || reg_we) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL trap_hold got illegal/enable violation want illegal=1 and no enables"); end
        rst_n = 1'b0; #1;
        checks++;
        if (illegal !== 1'b0 || instret !== 32'd0) begin
            errors++; $display("FAIL trap_reset illegal=%b instret=%0d want 0 0", illegal, instret);
        end
        release_reset();
        instret_m = '0;
        drive_instr(7'b0110011, 1'b0, 0, 0, "after_trap");
    endtask

    task automatic test_reset_in_store();
        int seen;
        ir_opcode = 7'b0100011; run = 1'b1; seen = 0;
        for (int c = 0; c < 20 && seen < 3; c++) begin
            @(negedge clk);
            mif.mem_ready = !(mif.mem_req && mif.mem_addr_sel);
            #1;
            if (mif.mem_we) seen++;
        end
        checks++;
        if (seen !== 3) begin errors++; $display("FAIL store_wait mem_we cycles got %0d want 3", seen); end
        rst_n = 1'b0; #1;
        checks++;
        if (mif.mem_req !== 1'b0 || mif.mem_we !== 1'b0 || instret !== 32'd0 || pc_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_store req=%b we=%b pc_we=%b instret=%0d want 0 0 0 0",
                     mif.mem_req, mif.mem_we, pc_we, instret);
        end
        release_reset();
        instret_m = '0;
        drive_instr(7'b0100011, 1'b0, 0, 1, "store_after_reset");
    endtask

    task automatic test_wrap();
        int got;
        logic [3:0] exp4;
        run = 1'b0;
        checks++;
        if (instret2 !== 4'd0) begin errors++; $display("FAIL wrap_start instret got %0d want 0", instret2); end
        run2 = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            got = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk); #1;
                if (pc_we2) begin got = 1; break; end
            end
            @(posedge clk); #1;
            if (n == 17) run2 = 1'b0;
            exp4 = 4'(n % 16);
            checks++;
            if (got !== 1 || instret2 !== exp4) begin
                errors++; $display("FAIL wrap_%0d instret got %0d want %0d (retired=%0d)", n, instret2, exp4, got);
            end
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load_wait();
        test_branch();
        test_jumps();
        test_random();
        test_trap();
        test_reset_in_store();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
